gravity_refill: RTL

GRAVITY_REFILL -- requirements
Module: gravity_refill

---
 rtl/match_pkg.sv | 34 +++
 rtl/color_lfsr.sv | 23 ++
 rtl/gravity_refill.sv | 137 +++++++++++++
 3 files changed

// File: rtl/match_pkg.sv
// Shared board geometry, cell encoding, FSM state type and colour helpers
// used by the gravity/refill stage of the match-3 pipeline.
package match_pkg;

  localparam int          ROWS       = 8;
  localparam int          COLS       = 8;
  localparam int          CELL_W     = 3;
  localparam logic [2:0]  EMPTY      = 3'd0;
  localparam int          NUM_COLORS = 5;
  localparam logic [6:0]  CNT_MAX    = 7'd64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  // One step of the 32-bit Fibonacci LFSR, taps 32, 22, 2, 1.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

  // Colour for a column: take the nibble at bit 2*col, fold into 1..ncolors.
  function automatic logic [2:0] pick_color(input logic [31:0] lfsr,
                                            input int col,
                                            input int ncolors);
    logic [31:0] sh;
    logic [3:0]  nib;
    sh  = lfsr >> (2 * col);
    nib = sh[3:0];
    return 3'((32'(nib) % 32'(ncolors)) + 32'd1);
  endfunction

endpackage

// File: rtl/color_lfsr.sv
// Free-running colour source: advances only when asked, keeps its state
// between requests, and reloads SEED on reset.
module color_lfsr
  import match_pkg::*;
#(
  parameter logic [31:0] SEED = 32'hACE1_2024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        advance,
  output logic [31:0] state
);

  // LFSR register: reload seed on reset, step when advance is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SEED;
    end else if (advance) begin
      state <= lfsr_next(state);
    end
  end

endmodule

// File: rtl/gravity_refill.sv
// Gravity/refill stage: repeatedly drops each column's pieces into its lowest
// hole while spawning a fresh colour at the top, until no hole remains.
module gravity_refill
  import match_pkg::*;
#(
  parameter int          ROWS       = match_pkg::ROWS,
  parameter int          COLS       = match_pkg::COLS,
  parameter int          NUM_COLORS = match_pkg::NUM_COLORS,
  parameter logic [31:0] SEED       = 32'hACE1_2024
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [ROWS*COLS*CELL_W-1:0]  board_in,
  output logic                         busy,
  output logic                         done,
  output logic [ROWS*COLS*CELL_W-1:0]  board_out,
  output logic [6:0]                   refill_cnt
);

  state_t                        state;
  logic [31:0]                   lfsr;
  logic                          advance;
  logic [ROWS*COLS*CELL_W-1:0]   next_board;
  logic [COLS-1:0]               col_has;
  logic                          any_zero;
  logic [7:0]                    col_sum;
  logic [7:0]                    cnt_sum;
  logic [6:0]                    cnt_next;

  // The colour source steps once on every FILL edge, including the last one.
  assign advance = (state == FILL);

  color_lfsr #(.SEED(SEED)) u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .advance (advance),
    .state   (lfsr)
  );

  for (genvar c = 0; c < COLS; c++) begin : g_col
    logic [ROWS*CELL_W-1:0] col_next;
    logic                   has_zero;
    logic [CELL_W-1:0]      new_color;

    assign new_color = pick_color(lfsr, c, NUM_COLORS);

    // Find this column's lowest hole and shift everything above it down one.
    always_comb begin : shift_col
      int  e;
      int  up;
      logic hit;
      e        = 0;
      has_zero = 1'b0;
      for (int r = 0; r < ROWS; r++) begin
        hit      = (board_out[CELL_W*(COLS*r+c) +: CELL_W] == EMPTY);
        e        = hit ? r : e;
        has_zero = has_zero | hit;
      end
      for (int r = 0; r < ROWS; r++) begin
        up = (r > 0) ? r - 1 : 0;
        if (!has_zero || (r > e)) begin
          col_next[CELL_W*r +: CELL_W] = board_out[CELL_W*(COLS*r+c) +: CELL_W];
        end else if (r == 0) begin
          col_next[CELL_W*r +: CELL_W] = new_color;
        end else begin
          col_next[CELL_W*r +: CELL_W] = board_out[CELL_W*(COLS*up+c) +: CELL_W];
        end
      end
    end

    assign col_has[c] = has_zero;

    for (genvar r = 0; r < ROWS; r++) begin : g_row
      assign next_board[CELL_W*(COLS*r+c) +: CELL_W] = col_next[CELL_W*r +: CELL_W];
    end
  end

  assign any_zero = |col_has;

  // Count columns refilled this edge and accumulate with saturation at 64.
  always_comb begin
    col_sum = 8'd0;
    for (int c = 0; c < COLS; c++) begin
      col_sum = col_sum + 8'(col_has[c]);
    end
    cnt_sum = {1'b0, refill_cnt} + col_sum;
    if (cnt_sum > {1'b0, CNT_MAX}) begin
      cnt_next = CNT_MAX;
    end else begin
      cnt_next = cnt_sum[6:0];
    end
  end

  // Control FSM with registered busy/done, working board and refill count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      board_out  <= '0;
      refill_cnt <= 7'd0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            board_out  <= board_in;
            refill_cnt <= 7'd0;
            busy       <= 1'b1;
            state      <= FILL;
          end
        end
        FILL: begin
          if (any_zero) begin
            board_out  <= next_board;
            refill_cnt <= cnt_next;
          end else begin
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
